sincronizador_vga: RTL
======================

# sincronizador_vga

VGA timing generator that turns the system clock into a pixel-rate tick and drives horizontal/vertical position counters, sync pulses and a visible-area flag. It sits directly downstream of the generic counter in the VGA path: it provides the scan position (x, y) and the pixel strobe that the pixel/colour stage consumes. It also provides hsync/vsync for the connector. Defaults give 640x480 @ 60 Hz from a 50 MHz clock.

## Interface
- DIV, 2: system clocks per pixel (>= 1)
- H_VISIBLE, 640 / H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal segments in pixels; H_TOTAL = sum = 800
- V_VISIBLE, 480 / V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical segments in lines; V_TOTAL = sum = 525
- ANCHO_X = $clog2(H_TOTAL), ANCHO_Y = $clog2(V_TOTAL) (derived, localparam; 10 and 10 at defaults)
- reloj  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of reloj
- habilitar  input  1  1 = run, 0 = freeze all counters
- pixel_tick  output  1  one-cycle strobe, once every DIV enabled cycles
- x  output  ANCHO_X  current h_cnt
- y  output  ANCHO_Y  current v_cnt
- hsync  output  1  horizontal sync, active-low
- vsync  output  1  vertical sync, active-low
- video_on  output  1  1 while (x, y) is inside the visible area
- inicio_cuadro  output  1  one-cycle strobe at the first pixel of each frame
- fin_linea  output  1  one-cycle strobe at the last pixel of each line

## Operation
- State: div_cnt (0..DIV-1), h_cnt (0..H_TOTAL-1), v_cnt (0..V_TOTAL-1), all registered.
- reset = 0 at a clock edge: div_cnt, h_cnt, v_cnt <= 0. Reset has priority over habilitar and overrides any mid-line or mid-frame position.
- pixel_tick = habilitar && (div_cnt == DIV-1). For DIV = 1, pixel_tick = habilitar.
- habilitar = 1: div_cnt increments and wraps from DIV-1 to 0.
- habilitar = 0: div_cnt, h_cnt, v_cnt hold. No strobes are produced.
- On an edge where pixel_tick = 1:
  - h_cnt increments. At H_TOTAL-1 it wraps to 0.
  - When h_cnt wraps, v_cnt increments. At V_TOTAL-1 it wraps to 0.
  - Both wrap in the same edge at (H_TOTAL-1, V_TOTAL-1).
- Decode is combinational from the registered counters:
  - hsync = 0 iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC
  - vsync = 0 iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC
  - video_on = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
  - x = h_cnt, y = v_cnt, unmasked; consumers gate them with video_on
  - inicio_cuadro = pixel_tick && h_cnt == 0 && v_cnt == 0
  - fin_linea = pixel_tick && h_cnt == H_TOTAL-1
- Arithmetic: all comparisons are unsigned at counter width. Counters never take a value >= their TOTAL.

## Timing
- Values while reset is held and on the first cycle after release:
  - div_cnt = 0, x = 0, y = 0
  - hsync = 1, vsync = 1, video_on = 1
  - pixel_tick = 0 (for DIV > 1), inicio_cuadro = 0, fin_linea = 0
- Ticks after reset release, with habilitar held high: the first pixel_tick is asserted DIV-1 cycles after release. At DIV = 2 that is cycle 1, and inicio_cuadro is asserted in that same cycle.
- Each (x, y) value is held for exactly DIV enabled cycles, and pixel_tick is asserted in the last of those cycles.
- Line period = H_TOTAL*DIV cycles (1600). Frame period = H_TOTAL*V_TOTAL*DIV cycles (840000).
- The hsync low pulse lasts H_SYNC*DIV cycles (192). The vsync low pulse lasts V_SYNC*H_TOTAL*DIV cycles (3200).
- Latency: sync, video_on, x and y change in the same cycle as the counter edge. There is no output pipeline stage.
- habilitar dropping low in the same cycle that pixel_tick would have been asserted suppresses that tick. Counting resumes from the frozen div_cnt.

## Test plan
- Reset then run: reset low for 3 cycles, then release with habilitar = 1 and DIV = 2 → x = 0, y = 0, hsync = 1, vsync = 1 at release; pixel_tick and inicio_cuadro asserted at cycle 1; x = 1 at cycle 2.
- Line timing:
  - hsync falls when x = 656 and rises when x = 752.
  - fin_linea is asserted with x = 799, then x wraps to 0 and y increments.
  - Consecutive fin_linea pulses are 1600 cycles apart.
- Frame timing:
  - vsync is low exactly while y is 490 or 491, for 3200 cycles.
  - Consecutive inicio_cuadro pulses are 840000 cycles apart.
  - video_on is high for 640*480*2 cycles per frame.
- Freeze: hold habilitar = 0 for 50 cycles at x = 100, y = 7 → x, y and div_cnt unchanged and no strobes. Restart resumes with the same phase.
- Reset mid-frame: pull reset low at x = 700, y = 300 for 1 cycle → next cycle x = 0, y = 0, hsync = 1, vsync = 1, and a new frame starts.
- DIV = 1 at a small geometry (H = 4/1/2/1, V = 3/1/1/1): pixel_tick is high every enabled cycle, the line is 8 cycles, the frame is 48 cycles, and the hsync/vsync windows match the decode formulas.

Source files
------------

// File: rtl/sincronizador_vga.sv
// sincronizador_vga
// VGA timing generator. Divides the system clock into a pixel-rate strobe,
// walks a horizontal/vertical scan position and decodes the sync pulses and
// the visible-area flag from that position. Defaults give 640x480 @ 60 Hz
// from a 50 MHz clock with DIV = 2.
//
// Ports
//   reloj          in   system clock, everything on the rising edge
//   reset          in   synchronous, active-low; wins over habilitar
//   habilitar      in   level enable: 1 = run, 0 = freeze every counter
//   pixel_tick     out  one-cycle strobe in the last enabled cycle of each pixel
//   x, y           out  raw scan position (not masked by video_on)
//   hsync, vsync   out  sync pulses, active-low
//   video_on       out  1 while (x, y) lies inside the visible area
//   inicio_cuadro  out  strobe on the pixel_tick of pixel (0, 0)
//   fin_linea      out  strobe on the pixel_tick of the last pixel of a line
//
// habilitar is a plain level enable, not a handshake: there is no ready
// path, and every output is valid in every cycle.
module sincronizador_vga #(
  parameter int DIV       = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  localparam int ANCHO_X  = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK),
  localparam int ANCHO_Y  = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK)
) (
  input  logic               reloj,
  input  logic               reset,
  input  logic               habilitar,
  output logic               pixel_tick,
  output logic [ANCHO_X-1:0] x,
  output logic [ANCHO_Y-1:0] y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               inicio_cuadro,
  output logic               fin_linea
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // A divider of 1 still needs a one-bit register; it simply stays at 0.
  localparam int ANCHO_D = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [ANCHO_D-1:0] DIV_LAST = ANCHO_D'(DIV - 1);
  localparam logic [ANCHO_X-1:0] H_LAST   = ANCHO_X'(H_TOTAL - 1);
  localparam logic [ANCHO_Y-1:0] V_LAST   = ANCHO_Y'(V_TOTAL - 1);

  // Decode bounds are kept at 32 bits: the end of a sync window can equal
  // the total, which would not fit at counter width when the back porch is 0.
  localparam logic [31:0] H_VIS_FIN = 32'(H_VISIBLE);
  localparam logic [31:0] HS_INI    = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0] HS_FIN    = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0] V_VIS_FIN = 32'(V_VISIBLE);
  localparam logic [31:0] VS_INI    = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0] VS_FIN    = 32'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [ANCHO_D-1:0] div_cnt_q, div_cnt_d;
  logic [ANCHO_X-1:0] h_cnt_q, h_cnt_d;
  logic [ANCHO_Y-1:0] v_cnt_q, v_cnt_d;
  logic               tick;
  logic [31:0]        h_ext, v_ext;

  // The strobe is combinational on habilitar, so dropping the enable in the
  // cycle the tick is due suppresses it and the divider phase is kept.
  assign tick = habilitar && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (habilitar) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge reloj) begin
    if (!reset) begin
      div_cnt_q <= '0;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
    end
  end

  // Output decode straight from the registered counters, no pipeline stage.
  always_comb begin
    h_ext         = 32'(h_cnt_q);
    v_ext         = 32'(v_cnt_q);
    pixel_tick    = tick;
    x             = h_cnt_q;
    y             = v_cnt_q;
    hsync         = !((h_ext >= HS_INI) && (h_ext < HS_FIN));
    vsync         = !((v_ext >= VS_INI) && (v_ext < VS_FIN));
    video_on      = (h_ext < H_VIS_FIN) && (v_ext < V_VIS_FIN);
    inicio_cuadro = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
    fin_linea     = tick && (h_cnt_q == H_LAST);
  end

endmodule
